// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake. Logic/arith ops finish in one
// cycle; shifts walk one bit per cycle and MUL is a W-step shift-add.
module alu_seq #(
    parameter int W     = 8,
    parameter int CTR_W = 12,
    parameter int SH_W  = $clog2(W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [W-1:0]     inA,
    input  logic [W-1:0]     inB,
    input  logic             shiftcarry_in,
    input  logic [CTR_W-1:0] reg_file_ctr,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     rslt,
    output logic [W-1:0]     rslt_hi,
    output logic             shiftcarry_out,
    output logic             branchFlag,
    output logic [CTR_W-1:0] alu_ctr
);
    localparam int CNT_W = SH_W + 1;
    localparam logic [3:0] OP_AND = 4'b0000, OP_XOR = 4'b0001, OP_OR  = 4'b0010,
                           OP_SHL = 4'b0011, OP_SHR = 4'b0100, OP_ADD = 4'b0101,
                           OP_SUB = 4'b0110, OP_MUL = 4'b0111, OP_LT  = 4'b1000,
                           OP_EQ  = 4'b1001, OP_ADC = 4'b1010;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [W-1:0]       rslt_q, rslt_d, rslt_hi_q, rslt_hi_d;
    logic               sco_q, sco_d, bf_q, bf_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d, tag_q, tag_d;
    logic               dir_q, dir_d, cin_q, cin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       wrk_q, wrk_d, hi_q, hi_d, mcand_q, mcand_d;

    logic [SH_W-1:0]    sh_amt;
    logic [W-1:0]       sc_rslt, sh_step;
    logic               sc_co, sc_bf, sh_bit;
    logic [W:0]         arith, mul_sum;

    assign sh_amt  = inB[SH_W-1:0];
    // dir_q=1 means shift right; the latched carry-in fills the vacated end
    assign sh_step = dir_q ? {cin_q, wrk_q[W-1:1]} : {wrk_q[W-2:0], cin_q};
    assign sh_bit  = dir_q ? wrk_q[0] : wrk_q[W-1];
    assign mul_sum = {1'b0, hi_q} + (wrk_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        sc_rslt = '0;
        sc_co   = 1'b0;
        sc_bf   = 1'b0;
        arith   = '0;
        case (ALUOp)
            OP_AND: sc_rslt = inA & inB;
            OP_XOR: sc_rslt = inA ^ inB;
            OP_OR:  sc_rslt = inA | inB;
            OP_SHL, OP_SHR: begin
                sc_rslt = inA;
                sc_co   = shiftcarry_in;
            end
            OP_ADD: begin
                arith   = {1'b0, inA} + {1'b0, inB};
                sc_rslt = arith[W-1:0];
                sc_co   = arith[W];
            end
            OP_ADC: begin
                arith   = {1'b0, inA} + {1'b0, inB} + (W+1)'(shiftcarry_in);
                sc_rslt = arith[W-1:0];
                sc_co   = arith[W];
            end
            OP_SUB: begin
                arith   = {1'b0, inA} - {1'b0, inB};
                sc_rslt = arith[W-1:0];
                sc_co   = arith[W];
            end
            OP_LT:   sc_bf = inA < inB;
            OP_EQ:   sc_bf = inA == inB;
            default: sc_rslt = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rslt_d    = rslt_q;
        rslt_hi_d = rslt_hi_q;
        sco_d     = sco_q;
        bf_d      = bf_q;
        ctr_d     = ctr_q;
        tag_d     = tag_q;
        dir_d     = dir_q;
        cin_d     = cin_q;
        cnt_d     = cnt_q;
        wrk_d     = wrk_q;
        hi_d      = hi_q;
        mcand_d   = mcand_q;
        case (state_q)
            IDLE: if (start) begin
                tag_d = reg_file_ctr;
                cin_d = shiftcarry_in;
                if ((ALUOp == OP_SHL || ALUOp == OP_SHR) && sh_amt != '0) begin
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                    dir_d   = ALUOp == OP_SHR;
                    wrk_d   = inA;
                    cnt_d   = {1'b0, sh_amt};
                end else if (ALUOp == OP_MUL) begin
                    state_d = MUL;
                    busy_d  = 1'b1;
                    wrk_d   = inB;
                    hi_d    = '0;
                    mcand_d = inA;
                    cnt_d   = CNT_W'(W);
                end else begin
                    done_d    = 1'b1;
                    rslt_d    = sc_rslt;
                    rslt_hi_d = '0;
                    sco_d     = sc_co;
                    bf_d      = sc_bf;
                    ctr_d     = reg_file_ctr;
                end
            end
            SHIFT: begin
                wrk_d = sh_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rslt_d    = sh_step;
                    rslt_hi_d = '0;
                    sco_d     = sh_bit;
                    bf_d      = 1'b0;
                    ctr_d     = tag_q;
                end
            end
            MUL: begin
                // product accumulates as {hi, wrk}; multiplier bits drain out of wrk's LSB
                hi_d  = mul_sum[W:1];
                wrk_d = {mul_sum[0], wrk_q[W-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rslt_d    = {mul_sum[0], wrk_q[W-1:1]};
                    rslt_hi_d = mul_sum[W:1];
                    sco_d     = 1'b0;
                    bf_d      = 1'b0;
                    ctr_d     = tag_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rslt_q    <= '0;
            rslt_hi_q <= '0;
            sco_q     <= 1'b0;
            bf_q      <= 1'b0;
            ctr_q     <= '0;
            tag_q     <= '0;
            dir_q     <= 1'b0;
            cin_q     <= 1'b0;
            cnt_q     <= '0;
            wrk_q     <= '0;
            hi_q      <= '0;
            mcand_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rslt_q    <= rslt_d;
            rslt_hi_q <= rslt_hi_d;
            sco_q     <= sco_d;
            bf_q      <= bf_d;
            ctr_q     <= ctr_d;
            tag_q     <= tag_d;
            dir_q     <= dir_d;
            cin_q     <= cin_d;
            cnt_q     <= cnt_d;
            wrk_q     <= wrk_d;
            hi_q      <= hi_d;
            mcand_q   <= mcand_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign rslt           = rslt_q;
    assign rslt_hi        = rslt_hi_q;
    assign shiftcarry_out = sco_q;
    assign branchFlag     = bf_q;
    assign alu_ctr        = ctr_q;
endmodule
